l1d_cache: RTL
==============

L1D_CACHE -- requirements
Module: l1d_cache

Interface
REQ-001 The module SHALL have exactly one clock and one reset, both listed first: clk, a single rising-edge clock, and reset, a synchronous active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 mem_read / mem_write  in  1 each  CPU data request strobes, held stable until mem_resp.
REQ-005 mem_address  in  16  CPU byte address; tag=[15:7], index=[6:4], word=[3:1], bit 0 ignored.
REQ-006 mem_wdata  in  16; mem_byte_enable  in  2  byte lanes for write (bit1=high byte).
REQ-007 mem_rdata  out  16; mem_resp  out  1  request completion.
REQ-008 pmem_read / pmem_write  out  1 each; pmem_address  out  16, line-aligned ([3:0]=0).
REQ-009 pmem_wdata  out  128; pmem_rdata  in  128; pmem_resp  in  1  physical-memory completion.
REQ-010 hit_count / miss_count  out  16 each  performance counters (see Configuration).

Function
REQ-011 Organisation SHALL be direct-mapped: 8 lines x 128-bit data, 9-bit tag, valid bit, dirty bit; write-back, write-allocate.
REQ-012 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE.
REQ-013 IDLE hit (request, valid, tag match): mem_resp=1 combinationally in the same cycle; read returns the selected word on mem_rdata in that cycle.
REQ-014 Write hit: enabled bytes merged into the line at the clock edge where mem_resp=1; dirty set to 1; disabled bytes unchanged.
REQ-015 IDLE miss, victim valid and dirty: next state WRITEBACK; otherwise ALLOCATE.
REQ-016 WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata=victim line; held until pmem_resp, then ALLOCATE.
REQ-017 ALLOCATE: pmem_read=1, pmem_address={req tag, index, 4'b0}; on pmem_resp the line, tag, valid=1 and dirty=0 are written, then IDLE.
REQ-018 After allocation the request SHALL be serviced as a hit in IDLE; minimum miss latency is 2 cycles plus pmem wait (clean) or 3 plus both waits (dirty).
REQ-019 mem_resp SHALL be 0 in WRITEBACK and ALLOCATE; pmem_read and pmem_write SHALL never be 1 simultaneously and both be 0 in IDLE.
REQ-020 mem_read and mem_write both 1 SHALL be treated as a write.
REQ-021 pmem_resp while in IDLE SHALL be ignored.
REQ-022 If the CPU request drops during a miss, the pending pmem transaction SHALL complete normally, then IDLE with no CPU-side array update.
REQ-023 mem_rdata SHALL be 16'h0000 whenever mem_resp=0.

Reset
REQ-024 reset SHALL clear all valid and dirty bits, set state IDLE, drive mem_resp, pmem_read and pmem_write to 0 from the next cycle, and zero both counters; data and tag arrays need not be cleared.
REQ-025 reset mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transaction; a late pmem_resp after reset SHALL be ignored.

Configuration
REQ-026 Macro L1D_PERF_CNT_EN: when defined, hit_count increments once per hit handshake (mem_resp=1) and miss_count once per IDLE->WRITEBACK/ALLOCATE transition, both 16-bit wrap-around (16'hFFFF->0).
REQ-027 Without L1D_PERF_CNT_EN, hit_count and miss_count SHALL be constant 0 and no counter registers are synthesised.

Verification
REQ-028 After reset, read 0x0042 with pmem_rdata line word1=16'hBEEF, pmem_resp after 3 cycles -> one ALLOCATE at pmem_address 0x0040, then mem_rdata=16'hBEEF with mem_resp; miss_count=1.
REQ-029 Write 0x0042 data 16'h1234 with byte_enable 2'b01 onto a resident line holding 16'hBEEF -> mem_resp same cycle; subsequent read returns 16'hBE34; hit_count increments by 2.
REQ-030 Dirty line tag 0 index 4, then read 0x0240 -> WRITEBACK at 0x0040 carrying the modified line, then ALLOCATE at 0x0240, then hit.
REQ-031 Assert reset during ALLOCATE, then pulse pmem_resp -> no line valid; re-read of same address misses again.
REQ-032 65536 hits with L1D_PERF_CNT_EN -> hit_count wraps to 0; same test without the macro -> both counters 0 throughout.
REQ-033 Drop mem_read during WRITEBACK -> writeback completes, ALLOCATE completes, IDLE, mem_resp never asserted.

Source files
------------

// File: rtl/l1d_cache.sv
`default_nettype none
// ============================================================================
// Module   : l1d_cache
// Purpose  : Direct-mapped, write-back, write-allocate L1 data cache.
//            8 lines x 128 bits, 9-bit tag, per-line valid and dirty bits.
//            Hits complete combinationally in IDLE; a miss optionally writes
//            back a dirty victim (WRITEBACK) and then fills the line
//            (ALLOCATE) before the request is serviced as a hit in IDLE.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            mem_read/mem_write         - CPU request strobes (both = write)
//            mem_address/mem_wdata      - CPU byte address / write data
//            mem_byte_enable            - write byte lanes (bit1 = high byte)
//            mem_rdata/mem_resp         - read data / request completion
//            pmem_read/pmem_write       - physical memory line strobes
//            pmem_address/pmem_wdata    - line-aligned address / victim line
//            pmem_rdata/pmem_resp       - fill line / pmem completion
//            hit_count/miss_count       - performance counters
// Config   : L1D_PERF_CNT_EN - when defined, hit_count/miss_count are live
//            16-bit wrapping counters; otherwise they are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module l1d_cache (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] data_q [8];
  logic [127:0] data_d [8];
  logic [8:0]   tag_q  [8];
  logic [8:0]   tag_d  [8];
  logic [7:0]   valid_q, valid_d;
  logic [7:0]   dirty_q, dirty_d;
  // Tag/index of the missing request, captured on entry to the miss path so
  // the pmem transaction stays coherent even if the CPU request goes away.
  logic [8:0]   miss_tag_q, miss_tag_d;
  logic [2:0]   miss_idx_q, miss_idx_d;

  logic [8:0]   req_tag;
  logic [2:0]   req_idx;
  logic [2:0]   req_word;
  logic         req_valid;
  logic         hit;
  logic [127:0] req_line;
  logic [127:0] merged_line;
  logic         hit_evt;
  logic         miss_evt;

  assign req_tag   = mem_address[15:7];
  assign req_idx   = mem_address[6:4];
  assign req_word  = mem_address[3:1];
  assign req_valid = mem_read | mem_write;
  assign req_line  = data_q[req_idx];
  assign hit       = (state_q == IDLE) && req_valid && valid_q[req_idx] &&
                     (tag_q[req_idx] == req_tag);

  // Byte-lane merge of the write data into the addressed word of the line.
  always_comb begin
    merged_line = req_line;
    if (mem_byte_enable[0]) merged_line[{req_word, 4'd0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[{req_word, 4'd8} +: 8] = mem_wdata[15:8];
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    hit_evt      = 1'b0;
    miss_evt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = req_line[{req_word, 4'd0} +: 16];
          hit_evt   = 1'b1;
          // A simultaneous read+write strobe is handled as a write.
          if (mem_write) begin
            data_d[req_idx]  = merged_line;
            dirty_d[req_idx] = 1'b1;
          end
        end else if (req_valid) begin
          miss_evt   = 1'b1;
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx_q], miss_idx_q, 4'd0};
        pmem_wdata   = data_q[miss_idx_q];
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_idx_q, 4'd0};
        if (pmem_resp) begin
          data_d[miss_idx_q]  = pmem_rdata;
          tag_d[miss_idx_q]   = miss_tag_q;
          valid_d[miss_idx_q] = 1'b1;
          dirty_d[miss_idx_q] = 1'b0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 8'h00;
      dirty_q    <= 8'h00;
      miss_tag_q <= 9'd0;
      miss_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  // Data and tag storage carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

`ifdef L1D_PERF_CNT_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + {15'd0, hit_evt};
    miss_count_d = miss_count_q + {15'd0, miss_evt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;

  logic unused_evts;
  assign unused_evts = hit_evt ^ miss_evt;
`endif

  // Byte address bit 0 does not select anything in a 16-bit word cache.
  logic unused_addr_bit;
  assign unused_addr_bit = mem_address[0];

endmodule
`default_nettype wire
